onchip_mem_arbiter: RTL and testbench

Two-master arbiter in front of the 2048x32 single-port on-chip RAM (sync address/write registers, unregistered q, byte enables, writes qualified by debugaccess). It lets the processor instruction port (m0) and data/debug port (m1) share the RAM with Avalon-MM-style waitrequest/readdatavalid handshakes. Sustains one access per cycle with a fixed one-cycle read latency.

---
 rtl/onchip_mem_arb_pkg.sv | 22 ++
 rtl/onchip_mem_arbiter_if.sv | 24 ++
 rtl/onchip_mem_arbiter_arb_rr2.sv | 38 +++
 rtl/onchip_mem_arbiter.sv | 82 ++++++++
 tb/tb_onchip_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_mem_arb_pkg.sv
// Shared constants and types for the two-master on-chip RAM arbiter.
package onchip_mem_arb_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_t;

    typedef struct packed {
        logic       valid;
        master_id_t id;
    } rd_tag_t;

    function automatic master_id_t other_id(input master_id_t id);
        return (id == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM-style master port bundle; one instance per master on the arbiter.
interface onchip_mem_arbiter_if;
    import onchip_mem_arb_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/onchip_mem_arbiter_arb_rr2.sv
// Two-request grant logic with last-grant pointer.
// ONCHIP_ARB_RR_EN selects round robin; otherwise m1 wins every contention.
module arb_rr2
    import onchip_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic       gnt_valid,
    output master_id_t gnt_id,
    output master_id_t last_id
);

    // Nothing is granted while reset is held, so both masters see waitrequest.
    always_comb begin
        gnt_valid = reset_n & (req[0] | req[1]);
        gnt_id    = M0;
        if (req[0] && req[1]) begin
`ifdef ONCHIP_ARB_RR_EN
            gnt_id = other_id(last_id);
`else
            gnt_id = M1;
`endif
        end else if (req[1]) begin
            gnt_id = M1;
        end
    end

    // Every grant goes to a requester, so a grant is always an accepted transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_id <= M1;
        end else if (gnt_valid) begin
            last_id <= gnt_id;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Arbiter sharing the 2048x32 single-port RAM between m0 (instr) and m1 (data/debug).
// Policy macro ONCHIP_ARB_RR_EN (round robin when defined, m1 fixed priority otherwise).
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    onchip_mem_arbiter_if.slave m0,
    onchip_mem_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [BE_W-1:0]     mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_debugaccess,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    logic [1:0]      req;
    logic            gnt_valid;
    master_id_t      gnt_id;
    master_id_t      last_id;
    master_id_t      sel_id;
    logic            sel_write;
    logic [BE_W-1:0] sel_be;
    rd_tag_t         rd_tag;

    assign req = {m1.read | m1.write, m0.read | m0.write};

    arb_rr2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .last_id   (last_id)
    );

    // Idle cycles park the RAM bus on the last granted master to limit toggling.
    assign sel_id = gnt_valid ? gnt_id : last_id;

    always_comb begin
        if (sel_id == M1) begin
            mem_address   = m1.address;
            mem_writedata = m1.writedata;
            sel_be        = m1.byteenable;
            sel_write     = m1.write;
        end else begin
            mem_address   = m0.address;
            mem_writedata = m0.writedata;
            sel_be        = m0.byteenable;
            sel_write     = m0.write;
        end
    end

    // A request with both read and write set is issued as a write.
    assign mem_chipselect  = gnt_valid;
    assign mem_write       = gnt_valid & sel_write;
    assign mem_debugaccess = mem_write;
    assign mem_byteenable  = mem_write ? sel_be : {BE_W{1'b1}};
    assign mem_clken       = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_tag <= '{valid: 1'b0, id: M0};
        end else begin
            rd_tag <= '{valid: gnt_valid & ~sel_write, id: sel_id};
        end
    end

    assign m0.waitrequest   = ~(gnt_valid & (gnt_id == M0));
    assign m1.waitrequest   = ~(gnt_valid & (gnt_id == M1));

    assign m0.readdatavalid = rd_tag.valid & (rd_tag.id == M0);
    assign m1.readdatavalid = rd_tag.valid & (rd_tag.id == M1);

    // RAM q is unregistered; the tag alone says who owns this cycle's data.
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural model of the 2048x32 RAM.
module tb_onchip_mem_arbiter;
    import onchip_mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    onchip_mem_arbiter_if m0 ();
    onchip_mem_arbiter_if m1 ();

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_chipselect;
    logic              mem_write;
    logic              mem_debugaccess;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    onchip_mem_arbiter dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .m0              (m0),
        .m1              (m1),
        .mem_address     (mem_address),
        .mem_byteenable  (mem_byteenable),
        .mem_writedata   (mem_writedata),
        .mem_chipselect  (mem_chipselect),
        .mem_write       (mem_write),
        .mem_debugaccess (mem_debugaccess),
        .mem_clken       (mem_clken),
        .mem_readdata    (mem_readdata)
    );

    // RAM model: unwritten word a reads as 0xC0DE0000 | a.
    logic [31:0] ram [0:2047];
    bit          written [0:2047];
    bit [10:0]   ram_addr_q;

    function automatic logic [31:0] ram_word(input logic [10:0] a);
        return written[a] ? ram[a] : (32'hC0DE0000 | {21'b0, a});
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_clken) ram_addr_q <= mem_address;
        if (mem_chipselect && mem_write && mem_debugaccess) begin
            ram[mem_address]     <= merge_be(ram_word(mem_address), mem_writedata, mem_byteenable);
            written[mem_address] <= 1'b1;
        end
    end

    always_comb mem_readdata = written[ram_addr_q] ? ram[ram_addr_q]
                                                   : (32'hC0DE0000 | {21'b0, ram_addr_q});

    int vectors;
    int miscompares;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0.read = 1'b0; m0.write = 1'b0; m0.address = '0; m0.byteenable = '0; m0.writedata = '0;
        m1.read = 1'b0; m1.write = 1'b0; m1.address = '0; m1.byteenable = '0; m1.writedata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

`ifdef ONCHIP_ARB_RR_EN
    localparam bit WIN1_AFTER_RESET = 1'b0;
`else
    localparam bit WIN1_AFTER_RESET = 1'b1;
`endif

    logic [4:0] t_w0, t_w1, t_rdv0, t_rdv1;
    logic       exp_g1, prev_g1, win1, drop_m0;
    int         rdv0_count;

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle_all();
        reset_n     = 1'b0;

        // Reset held with m0 already requesting: no grant, no responses.
        m0.read = 1'b1; m0.address = 11'h005;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wait0", m0.waitrequest, 1);
        check("rst_wait1", m1.waitrequest, 1);
        check("rst_rdv0", m0.readdatavalid, 0);
        check("rst_rdv1", m1.readdatavalid, 0);
        check("rst_cs", mem_chipselect, 0);
        check("rst_mwr", mem_write, 0);
        check("clken", mem_clken, 1);

        // First cycle after release: m0 read of 0x005 granted immediately.
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rd5_wait0", m0.waitrequest, 0);
        check("rd5_wait1", m1.waitrequest, 1);
        check("rd5_cs", mem_chipselect, 1);
        check("rd5_addr", mem_address, 11'h005);
        check("rd5_be", mem_byteenable, 4'hF);
        check("rd5_mwr", mem_write, 0);
        next_cycle(); idle_all();
        @(negedge clk);
        check("rd5_rdv0", m0.readdatavalid, 1);
        check("rd5_data", m0.readdata, 32'hC0DE0005);
        check("rd5_rdv1", m1.readdatavalid, 0);
        next_cycle();
        @(negedge clk);
        check("rd5_rdv0_gone", m0.readdatavalid, 0);

        // m1 partial write then read-back of 0x010.
        next_cycle();
        m1.write = 1'b1; m1.address = 11'h010; m1.byteenable = 4'b0011; m1.writedata = 32'hDEADBEEF;
        @(negedge clk);
        check("wr10_wait1", m1.waitrequest, 0);
        check("wr10_mwr", mem_write, 1);
        check("wr10_dbg", mem_debugaccess, 1);
        check("wr10_be", mem_byteenable, 4'b0011);
        check("wr10_wd", mem_writedata, 32'hDEADBEEF);
        check("wr10_addr", mem_address, 11'h010);
        next_cycle();
        m1.write = 1'b0; m1.read = 1'b1; m1.byteenable = 4'b0000;
        @(negedge clk);
        check("rd10_wait1", m1.waitrequest, 0);
        check("rd10_dbg", mem_debugaccess, 0);
        check("rd10_be", mem_byteenable, 4'hF);
        check("wr10_noresp", m1.readdatavalid, 0);
        next_cycle(); idle_all();
        @(negedge clk);
        check("rd10_rdv1", m1.readdatavalid, 1);
        check("rd10_data", m1.readdata, 32'hC0DEBEEF);
        check("rd10_rdv0", m0.readdatavalid, 0);

        // Both masters reading continuously.
        next_cycle();
        m0.read = 1'b1; m0.address = 11'h020;
        m1.read = 1'b1; m1.address = 11'h030;
        prev_g1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifdef ONCHIP_ARB_RR_EN
            exp_g1 = (k % 2) == 1;
`else
            exp_g1 = 1'b1;
`endif
            @(negedge clk);
            check($sformatf("cont%0d_wait0", k), m0.waitrequest, exp_g1);
            check($sformatf("cont%0d_wait1", k), m1.waitrequest, !exp_g1);
            check($sformatf("cont%0d_rdv0", k), m0.readdatavalid, (k > 0) && !prev_g1);
            check($sformatf("cont%0d_rdv1", k), m1.readdatavalid, (k > 0) && prev_g1);
            if (k > 0)
                check($sformatf("cont%0d_data", k), m0.readdata,
                      prev_g1 ? 32'hC0DE0030 : 32'hC0DE0020);
            prev_g1 = exp_g1;
            next_cycle();
        end
        idle_all();
        @(negedge clk);
        check("cont_tail_rdv1", m1.readdatavalid, 1);
        check("cont_tail_rdv0", m0.readdatavalid, 0);
        check("cont_tail_data", m1.readdata, 32'hC0DE0030);

        // Reset pulsed the cycle after an accepted m0 read: return discarded.
        next_cycle();
        m0.read = 1'b1; m0.address = 11'h040;
        @(negedge clk);
        check("rdrst_wait0", m0.waitrequest, 0);
        next_cycle(); idle_all();
        reset_n = 1'b0;
        @(negedge clk);
        check("rdrst_rdv0", m0.readdatavalid, 0);
        check("rdrst_rdv1", m1.readdatavalid, 0);
        check("rdrst_cs", mem_chipselect, 0);
        check("rdrst_mwr", mem_write, 0);
        check("rdrst_wait0_idle", m0.waitrequest, 1);
        check("rdrst_wait1_idle", m1.waitrequest, 1);
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        check("rdrst_post_rdv0", m0.readdatavalid, 0);
        check("rdrst_post_rdv1", m1.readdatavalid, 0);

        // First contention after reset: round robin gives m0, fixed gives m1.
        next_cycle();
        m0.read = 1'b1; m0.address = 11'h050;
        m1.read = 1'b1; m1.address = 11'h060;
        win1 = WIN1_AFTER_RESET;
        @(negedge clk);
        check("ctd_wait0", m0.waitrequest, win1);
        check("ctd_wait1", m1.waitrequest, !win1);
        next_cycle();
        if (win1) m1.read = 1'b0; else m0.read = 1'b0;
        @(negedge clk);
        check("ctd_loser_wait", win1 ? m0.waitrequest : m1.waitrequest, 0);
        check("ctd_win_rdv", win1 ? m1.readdatavalid : m0.readdatavalid, 1);
        check("ctd_win_data", m0.readdata, win1 ? 32'hC0DE0060 : 32'hC0DE0050);
        next_cycle(); idle_all();
        @(negedge clk);
        check("ctd_lose_rdv", win1 ? m0.readdatavalid : m1.readdatavalid, 1);
        check("ctd_lose_data", m1.readdata, win1 ? 32'hC0DE0050 : 32'hC0DE0060);

        // m0 writes the top word, m1 reads it the next cycle.
        next_cycle();
        m0.write = 1'b1; m0.address = 11'h7FF; m0.byteenable = 4'hF; m0.writedata = 32'h12345678;
        @(negedge clk);
        check("wr7ff_wait0", m0.waitrequest, 0);
        check("wr7ff_mwr", mem_write, 1);
        next_cycle(); idle_all();
        m1.read = 1'b1; m1.address = 11'h7FF;
        @(negedge clk);
        check("rd7ff_wait1", m1.waitrequest, 0);
        next_cycle(); idle_all();
        @(negedge clk);
        check("rd7ff_rdv1", m1.readdatavalid, 1);
        check("rd7ff_data", m1.readdata, 32'h12345678);

        // m0 reads it back too, leaving m0 as the last granted master.
        next_cycle();
        m0.read = 1'b1; m0.address = 11'h7FF;
        @(negedge clk);
        check("rd7ff_m0_wait0", m0.waitrequest, 0);
        next_cycle(); idle_all();
        @(negedge clk);
        check("rd7ff_m0_rdv0", m0.readdatavalid, 1);
        check("rd7ff_m0_data", m0.readdata, 32'h12345678);

        // m0 holds a read while m1 issues three reads.
`ifdef ONCHIP_ARB_RR_EN
        t_w0 = 5'b11101; t_w1 = 5'b11010; t_rdv0 = 5'b00100; t_rdv1 = 5'b01010;
`else
        t_w0 = 5'b10111; t_w1 = 5'b11000; t_rdv0 = 5'b10000; t_rdv1 = 5'b01110;
`endif
        next_cycle();
        m0.read = 1'b1; m0.address = 11'h070;
        m1.read = 1'b1; m1.address = 11'h080;
        rdv0_count = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d_wait0", k), m0.waitrequest, t_w0[k]);
            check($sformatf("hold%0d_wait1", k), m1.waitrequest, t_w1[k]);
            check($sformatf("hold%0d_rdv0", k), m0.readdatavalid, t_rdv0[k]);
            check($sformatf("hold%0d_rdv1", k), m1.readdatavalid, t_rdv1[k]);
            if (m0.readdatavalid) begin
                rdv0_count++;
                check($sformatf("hold%0d_data0", k), m0.readdata, 32'hC0DE0070);
            end
            drop_m0 = m0.read && !m0.waitrequest;
            next_cycle();
            if (drop_m0) m0.read = 1'b0;
            if (k >= 2) m1.read = 1'b0;
        end
        check("hold_rdv0_count", rdv0_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
